// File: rtl/serial_add_seq.sv
// serial_add_seq
//
// LSB-first serial adder with start/done handshake. Two N-bit operands are
// captured on an accepted start, streamed one bit per clock through a single
// full-adder stage with a carry flip-flop, and the N-bit sum plus carry-out
// are captured into output registers on the last shift edge.
//
// Ports
//   clock   rising-edge clock for all state
//   reset   synchronous, active-high reset
//   start   request a new operation (sampled only while ready=1)
//   x, y    N-bit operands, captured on the accepted start edge
//   sub     (only with SERIAL_ADD_SUB_EN) 1 selects x - y
//   ready   high in IDLE
//   busy    high in SHIFT and DONE
//   done    one-cycle pulse; sum/cout hold the new result
//   sum     registered N-bit result (modulo 2^N)
//   cout    registered final carry (for subtract: 1 = no borrow)
//
// Build option
//   SERIAL_ADD_SUB_EN  adds the sub port; subtract is x + ~y + 1.
//
// state   | meaning
// --------+--------------------------------------------------------
// S_IDLE  | waiting for start; operands and carry load on accept
// S_SHIFT | one bit per edge through the full adder, N edges total
// S_DONE  | result registers updated; done pulses for this cycle

module serial_add_seq #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
`ifdef SERIAL_ADD_SUB_EN
    input  logic         sub,
`endif
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic [N-1:0]  w_reg;
    logic          c_reg;
    logic [CW-1:0] cnt;

    logic          s_bit;
    logic          c_next;
    logic [N-1:0]  w_next;
    logic          last_bit;
    logic          load_sub;
    logic [N-1:0]  b_load;

`ifdef SERIAL_ADD_SUB_EN
    assign load_sub = sub;
`else
    assign load_sub = 1'b0;
`endif

    // Subtract is x + ~y + 1: invert B on load and preset the carry.
    assign b_load   = load_sub ? ~y : y;

    assign s_bit    = a_reg[0] ^ b_reg[0] ^ c_reg;
    assign c_next   = (a_reg[0] & b_reg[0]) | (a_reg[0] & c_reg) | (b_reg[0] & c_reg);
    assign last_bit = (cnt == CW'(N - 1));

    // Shift-in at the MSB written via index so N=1 needs no special case.
    always_comb begin
        w_next        = w_reg >> 1;
        w_next[N-1]   = s_bit;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_reg <= '0;
            b_reg <= '0;
            w_reg <= '0;
            c_reg <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg <= x;
                        b_reg <= b_load;
                        w_reg <= '0;
                        c_reg <= load_sub;
                        cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    a_reg <= a_reg >> 1;
                    b_reg <= b_reg >> 1;
                    w_reg <= w_next;
                    c_reg <= c_next;
                    cnt   <= cnt + CW'(1);
                    // Capture includes this edge's sum bit and carry.
                    if (last_bit) begin
                        sum  <= w_next;
                        cout <= c_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/serial_add_seq.md
# serial_add_seq

Sequenced LSB-first serial adder with a start/done handshake. Loads two N-bit operands, streams them one bit per clock through a single full-adder stage with a carry flip-flop, and presents the registered N-bit sum plus carry-out. It wraps the serial add datapath with the load, count and capture control the bare datapath lacks. The bus-side parallel logic sits upstream and the result consumer sits downstream.

## Interface
- `N`, default 8: operand and sum width; legal N ≥ 1.

- `clock` in 1: rising-edge clock for all state.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request a new operation; sampled only while `ready`=1.
- `x` in N: operand A; captured on the accepted `start` edge.
- `y` in N: operand B; captured on the accepted `start` edge.
- `sub` in 1: present only with `SERIAL_ADD_SUB_EN`; captured with operands; 1 selects x − y.
- `ready` out 1: high in IDLE only.
- `busy` out 1: high in SHIFT and DONE.
- `done` out 1: one-cycle pulse; `sum`/`cout` are valid and updated.
- `sum` out N: registered result.
- `cout` out 1: registered final carry.

## Operation
- States are IDLE, SHIFT and DONE; the encoding is free.
- IDLE → SHIFT on `start`=1, with these actions in the same edge:
  - load `x` into shift register A and `y` into shift register B;
  - clear bit counter `cnt` (width ⌈log2 N⌉, minimum 1);
  - clear carry `c`, or set it to 1 when subtracting;
  - B is loaded inverted when subtracting.
- SHIFT, per edge:
  - s = A[0] ^ B[0] ^ c;
  - c ← majority(A[0], B[0], c);
  - A and B shift right with 0 fill;
  - work register W shifts right with s entering the MSB;
  - `cnt` increments.
- SHIFT → DONE on the edge where `cnt` = N−1 (N-th bit processed). The same edge does the following:
  - loads `sum` ← final W, including that edge's s;
  - loads `cout` ← final carry.
- DONE → IDLE unconditionally after one cycle.
- `start` is ignored in SHIFT and DONE; `x`/`y`/`sub` may change freely after acceptance.
- `sum`/`cout` change only on the SHIFT→DONE edge and on reset. They hold the previous result throughout a new operation.
- Arithmetic is modulo 2^N.
  - Add: `cout` = bit N of x+y.
  - Subtract: `cout` = 1 when x ≥ y (no borrow), 0 on borrow.
- N=1: SHIFT lasts exactly one cycle.

## Timing
- `start` is accepted at edge E0. SHIFT is active for edges E1..EN.
- The DONE state and the `done` pulse are visible during the cycle after edge EN. That is N+1 cycles from the accepting edge to `done` high.
- The earliest next accept is edge EN+2 (back in IDLE). Throughput is one op per N+2 cycles with `start` held high.
- Reset, at any edge and in any state, including mid-SHIFT:
  - state → IDLE; the operation is abandoned;
  - `sum`=0, `cout`=0, `done`=0, `busy`=0, `ready`=1 in the following cycle;
  - A, B, W, `c` and `cnt` are cleared.
- Reset and `start` on the same edge: reset wins and the operation is not accepted.
- All outputs are registered or decoded from state only; no combinational path from inputs.

## Configuration
- `SERIAL_ADD_SUB_EN` defined:
  - the `sub` port exists;
  - subtract is performed as x + ~y + 1 via inverted B load and carry preset to 1.
- `SERIAL_ADD_SUB_EN` undefined:
  - no `sub` port;
  - the carry always starts at 0; add only;
  - the port list is otherwise identical.

## Test plan
- N=8, x=8'h3C, y=8'h0F, start one cycle → `done` high exactly 9 cycles after the accepting edge, `sum`=8'h4B, `cout`=0.
- N=8, x=8'hFF, y=8'h01 → `sum`=8'h00, `cout`=1. Then x=8'h80, y=8'h80 → `sum`=8'h00, `cout`=1.
- Pulse `start` again 3 cycles into SHIFT with different operands → pulse ignored, first result unchanged, `ready` stays 0 until IDLE.
- Assert `reset` 4 cycles into SHIFT → next cycle `ready`=1, `busy`=0, `done`=0, `sum`=0, `cout`=0; no `done` pulse ever appears for the aborted op.
- `start` held high continuously with x=1, y=2 → `done` pulses every 10 cycles, `sum`=3 each time; `sum` holds its value between pulses.
- With `SERIAL_ADD_SUB_EN`:
  - x=8'h05, y=8'h07, `sub`=1 → `sum`=8'hFE, `cout`=0;
  - x=8'h07, y=8'h05 → `sum`=8'h02, `cout`=1.
